// File: rtl/fifo_status.sv
// Synchronous FIFO with occupancy count, almost-full/almost-empty thresholds and flush.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise they are tied low.
module fifo_status #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 2,
  parameter int AFULL_TH  = 3,
  parameter int AEMPTY_TH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int            DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  logic              r_empty;
  logic              r_full;
  logic              r_aempty;
  logic              r_afull;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [ADDR_W:0]   w_count_next;

  // Acceptance uses the registered flags, so a simultaneous request at a
  // boundary degenerates to the single legal operation.
  assign w_wr_acc     = wr & ~r_full;
  assign w_rd_acc     = rd & ~r_empty;
  assign w_count_next = r_count + (ADDR_W+1)'(w_wr_acc) - (ADDR_W+1)'(w_rd_acc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_aempty <= 1'b1;
      r_afull  <= 1'b0;
    end else if (flush) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_aempty <= 1'b1;
      r_afull  <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      r_count  <= w_count_next;
      r_empty  <= (w_count_next == '0);
      r_full   <= (w_count_next == DEPTH_C);
      r_aempty <= (w_count_next <= AEMPTY_C);
      r_afull  <= (w_count_next >= AFULL_C);
    end
  end

  // Storage has no reset; the reset term only blocks a write racing reset assertion.
  always_ff @(posedge clk) begin
    if (!reset && !flush && w_wr_acc) r_mem[r_wptr] <= w_data;
  end

  assign r_data       = r_mem[r_rptr];
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_aempty;
  assign almost_full  = r_afull;
  assign count        = r_count;

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr && r_full)  r_overflow  <= 1'b1;
      if (rd && r_empty) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: doc/fifo_status.md
# fifo_status

Parametrised synchronous FIFO with occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush, and optional sticky overflow/underflow error flags. It supersedes the basic 2^W-entry FIFO for buffering between producer and consumer stages in the same clock domain, such as UART/keyboard byte streams or display command queues. It fixes simultaneous read/write at the empty and full boundaries so the pointers never corrupt.

## Interface
- DATA_W, 8, bits per word
- ADDR_W, 2, address bits; DEPTH = 2**ADDR_W entries
- AFULL_TH, 3, almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH
- AEMPTY_TH, 1, almost_empty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous clear of contents and flags
- wr  in  1  write request
- w_data  in  DATA_W  write data
- rd  in  1  read request (pop)
- r_data  out  DATA_W  head-of-queue word (show-ahead)
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count <= AEMPTY_TH
- almost_full  out  1  count >= AFULL_TH
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Write accepted (wr_acc) = wr & ~full. Read accepted (rd_acc) = rd & ~empty. Both are evaluated on registered flags.
- wr_acc: stores w_data at w_ptr; w_ptr increments modulo DEPTH.
- rd_acc: r_ptr increments modulo DEPTH.
- count_next = count + wr_acc - rd_acc. Arithmetic is ADDR_W+1 bits and never wraps.
- Both requests while empty: write only, count becomes 1. Both requests while full: read only, count becomes DEPTH-1. Both requests otherwise: both accepted, count unchanged.
- Rejected requests leave pointers, count, and storage untouched.
- empty, full, almost_empty, and almost_full are registered and derived from count_next.
- r_data = mem[r_ptr], combinational from the registered pointer. It is valid only while empty=0 and is unchecked while empty=1.
- flush=1: pointers and count go to 0 and all flags go to their reset values. Flush takes priority over rd and wr in the same cycle, and the memory contents are not cleared.
- Reset values: count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, pointers=0.
- Reset is asynchronous. When asserted mid-operation, all of the above take their reset values immediately and any in-flight write is discarded.

## Timing
- Write-to-read latency is 1 cycle. A word written at edge N appears on r_data and empty falls after edge N.
- Read is show-ahead. The consumer samples r_data while asserting rd, and the next word appears after that edge.
- Every status output changes only on the rising clk edge, except on reset assertion.
- Error flags set on the edge following the violating request and hold until flush or reset.
- flush and a violation in the same cycle: flush wins and the flag stays 0.

## Configuration
- FIFO_ERR_FLAGS_EN defined: overflow and underflow are implemented as sticky registers, as described above.
- FIFO_ERR_FLAGS_EN undefined: overflow and underflow are tied to 0 with no registers. All other behaviour is identical.

## Test plan
- Reset, then write 0x11, 0x22, 0x33, 0x44 (DEPTH=4) -> count 1,2,3,4. almost_full rises after the 3rd write, full after the 4th. A 5th write of 0x55 is rejected, the contents stay unchanged, and overflow=1 when FIFO_ERR_FLAGS_EN is defined.
- Drain the full FIFO with rd held 4 cycles -> r_data sequence 0x11, 0x22, 0x33, 0x44. empty=1 after the 4th edge and almost_empty=1 from count=1. A further rd gives underflow=1 and count stays 0.
- Empty FIFO, wr=rd=1 with 0xA5 -> count=1, empty=0, r_data=0xA5. Full FIFO, wr=rd=1 with 0x5A -> count=3 and 0x5A is not stored.
- Write 6 and read 6 words interleaved, crossing pointer wrap -> FIFO order is preserved. Steady wr=rd at count=2 holds count at 2.
- count=3 with overflow=1, assert flush together with wr -> next cycle count=0, empty=1, overflow=0, and the write is discarded.
- Assert reset asynchronously between edges at count=2 -> outputs take their reset values immediately. After release, a write of 0x77 reads back as 0x77.
